// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: upstream feeder for the 6-bit mini ALU.
// Collects operand A, operand B and the function code, one word at a time,
// from a shared valid/ready input stream. It holds them on the ALU input pins,
// waits a programmable settle time, then captures the ALU result and presents
// it on a valid/ready output channel. It also counts completed result handshakes.
//
// Ports:
//   clk, reset                     rising-edge clock, async active-high reset
//   in_data/in_valid/in_ready      shared operand/opcode input stream
//   alu_a/alu_b/alu_fxn            registered drives to the ALU inputs
//   alu_result                     combinational ALU finalresult
//   res_data/res_valid/res_ready   captured-result output stream
//   busy                           high whenever not waiting for operand A
//   op_count                       completed result handshakes, wrapping
module alu_operand_sequencer #(
  parameter int unsigned DATA_W        = 6,
  parameter int unsigned FXN_W         = 3,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FXN_W-1:0]  alu_fxn,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned SET_W = 4;

  typedef enum logic [2:0] {
    S_A      = 3'd0,
    S_B      = 3'd1,
    S_FXN    = 3'd2,
    S_SETTLE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [FXN_W-1:0]    alu_fxn_q, alu_fxn_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;
  logic [SET_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                xfer;

  // Input transfer happens only when the registered ready meets a valid word.
  assign xfer = in_valid && in_ready_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fxn_d   = alu_fxn_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    cnt_d       = cnt_q;
    in_ready_d  = 1'b0;
    busy_d      = 1'b1;

    case (state_q)
      S_A: begin
        if (xfer) begin
          alu_a_d = in_data;
          state_d = S_B;
        end
      end
      S_B: begin
        if (xfer) begin
          alu_b_d = in_data;
          state_d = S_FXN;
        end
      end
      S_FXN: begin
        if (xfer) begin
          alu_fxn_d = in_data[FXN_W-1:0];
          // The cycle in which the new opcode first reaches the ALU pins is
          // followed by SETTLE_CYCLES full settle cycles, so the result is
          // registered SETTLE_CYCLES+1 edges after the opcode edge.
          cnt_d     = SET_W'(SETTLE_CYCLES);
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          res_data_d  = alu_result;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q - SET_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = S_A;
        end
      end
      default: state_d = S_A;
    endcase

    // Handshake flags are registered, decoded from the upcoming state.
    in_ready_d = (state_d == S_A) || (state_d == S_B) || (state_d == S_FXN);
    busy_d     = (state_d != S_A);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fxn_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fxn_q   <= alu_fxn_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fxn   = alu_fxn_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: two instances (settle 1 and 3)
// drive a behavioural mini-ALU; expected results are queued at issue time and
// popped by a monitor on each result handshake.
module tb_alu_operand_sequencer;

  localparam int unsigned DW = 6;
  localparam int unsigned FW = 3;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0 (SETTLE_CYCLES=1) signals
  logic [DW-1:0] in_data0, alu_a0, alu_b0, alu_result0, res_data0;
  logic [FW-1:0] alu_fxn0;
  logic          in_valid0, in_ready0, res_valid0, res_ready0, busy0;
  logic [CW-1:0] op_count0;
  // Instance 1 (SETTLE_CYCLES=3) signals
  logic [DW-1:0] in_data1, alu_a1, alu_b1, alu_result1, res_data1;
  logic [FW-1:0] alu_fxn1;
  logic          in_valid1, in_ready1, res_valid1, res_ready1, busy1;
  logic [CW-1:0] op_count1;

  alu_operand_sequencer #(.DATA_W(DW), .FXN_W(FW), .SETTLE_CYCLES(1), .CNT_W(CW)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_fxn(alu_fxn0), .alu_result(alu_result0),
    .res_data(res_data0), .res_valid(res_valid0), .res_ready(res_ready0),
    .busy(busy0), .op_count(op_count0));

  alu_operand_sequencer #(.DATA_W(DW), .FXN_W(FW), .SETTLE_CYCLES(3), .CNT_W(CW)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_fxn(alu_fxn1), .alu_result(alu_result1),
    .res_data(res_data1), .res_valid(res_valid1), .res_ready(res_ready1),
    .busy(busy1), .op_count(op_count1));

  // Behavioural mini ALU (combinational finalresult)
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [FW-1:0] f);
    case (f)
      3'd0:    alu_ref = a & b;
      3'd1:    alu_ref = a | b;
      3'd2:    alu_ref = a ^ b;
      3'd4:    alu_ref = {5'b00000, (a < b)};
      3'd5:    alu_ref = ~(a ^ b);
      3'd6:    alu_ref = a + b;
      3'd7:    alu_ref = a - b;
      default: alu_ref = ~a;
    endcase
  endfunction

  assign alu_result0 = alu_ref(alu_a0, alu_b0, alu_fxn0);
  assign alu_result1 = alu_ref(alu_a1, alu_b1, alu_fxn1);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_q[$];
  int            fxn_edge[2];
  logic          prev_v[2];
  logic [CW-1:0] exp_cnt[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-instance monitor step, evaluated mid-cycle.
  task automatic mon(input int k, input logic v, input logic rr, input logic [DW-1:0] d,
                     input logic ir, input logic [CW-1:0] cnt);
    logic [DW-1:0] e;
    if (reset) begin
      exp_cnt[k] = '0;
      prev_v[k]  = 1'b0;
      return;
    end
    chk("op_count", int'(cnt), int'(exp_cnt[k]));
    chk("ready_valid_overlap", int'(v && ir), 0);
    if (v && !prev_v[k])
      chk("res_valid_latency", cyc - fxn_edge[k], (k == 0) ? 2 : 4);
    prev_v[k] = v;
    if (v && rr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(d), -1);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", int'(d), int'(e));
      end
      exp_cnt[k] = exp_cnt[k] + CW'(1);
    end
  endtask

  initial begin
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    fxn_edge[0] = 0; fxn_edge[1] = 0;
    forever begin
      @(negedge clk);
      mon(0, res_valid0, res_ready0, res_data0, in_ready0, op_count0);
      mon(1, res_valid1, res_ready1, res_data1, in_ready1, op_count1);
    end
  end

  // Present one word and wait (bounded) for its transfer edge.
  task automatic send(input int k, input logic [DW-1:0] w, input bit is_fxn);
    bit ok = 1'b0;
    if (k == 0) begin in_data0 = w; in_valid0 = 1'b1; end
    else        begin in_data1 = w; in_valid1 = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((k == 0) ? in_ready0 : in_ready1) begin ok = 1'b1; break; end
    end
    chk("in_ready_wait", int'(ok), 1);
    @(posedge clk); #2;
    if (is_fxn) fxn_edge[k] = cyc;
  endtask

  task automatic op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                    input logic [DW-1:0] f, input logic [DW-1:0] exp, input bit push);
    if (push) exp_q.push_back(exp);
    send(k, a, 1'b0);
    send(k, b, 1'b0);
    send(k, f, 1'b1);
  endtask

  task automatic idle(input int k);
    if (k == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    idle(k);
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a, b, e;
    logic [FW-1:0] f;
    reset = 1'b1;
    in_data0 = '0; in_valid0 = 1'b0; res_ready0 = 1'b1;
    in_data1 = '0; in_valid1 = 1'b0; res_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_res_valid", int'(res_valid0), 0);
    chk("rst_alu_a", int'(alu_a0), 0);
    chk("rst_alu_b", int'(alu_b0), 0);
    chk("rst_alu_fxn", int'(alu_fxn0), 0);
    chk("rst_res_data", int'(res_data0), 0);
    chk("rst_op_count", int'(op_count0), 0);
    @(posedge clk); #2;

    // Reset asserted mid-settle discards the operation
    op(0, 6'd7, 6'd1, 6'd6, 6'd0, 1'b0);
    idle(0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_alu_a", int'(alu_a0), 0);
    chk("abort_alu_b", int'(alu_b0), 0);
    chk("abort_alu_fxn", int'(alu_fxn0), 0);
    chk("abort_res_valid", int'(res_valid0), 0);
    chk("abort_op_count", int'(op_count0), 0);
    chk("abort_in_ready", int'(in_ready0), 1);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2;
    op(0, 6'd7, 6'd1, 6'd6, 6'd8, 1'b1);
    drain(0);

    // 5 + 3 with in_valid held high
    op(0, 6'd5, 6'd3, 6'd6, 6'd8, 1'b1);
    chk("add_alu_a", int'(alu_a0), 5);
    chk("add_alu_b", int'(alu_b0), 3);
    chk("add_alu_fxn", int'(alu_fxn0), 6);
    drain(0);
    @(negedge clk);
    chk("add_op_count", int'(op_count0), 2);
    @(posedge clk); #2;

    // 10 - 20 on the SETTLE_CYCLES=3 instance
    op(1, 6'd10, 6'd20, 6'd7, 6'b110110, 1'b1);
    drain(1);

    // 2 < 9 with back-pressure on the result
    res_ready0 = 1'b0;
    op(0, 6'd2, 6'd9, 6'd4, 6'd1, 1'b1);
    idle(0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (res_valid0) begin seen = 1'b1; break; end
      end
      chk("lt_res_valid_rise", int'(seen), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_res_data", int'(res_data0), 1);
      chk("hold_res_valid", int'(res_valid0), 1);
      chk("hold_in_ready", int'(in_ready0), 0);
      chk("hold_busy", int'(busy0), 1);
    end
    @(posedge clk); #2 res_ready0 = 1'b1;
    @(posedge clk); #2;
    chk("post_hs_in_ready", int'(in_ready0), 1);
    chk("post_hs_busy", int'(busy0), 0);
    chk("post_hs_res_valid", int'(res_valid0), 0);

    // Upper opcode bits discarded: XNOR
    op(0, 6'b101010, 6'b110011, 6'b111101, 6'b100110, 1'b1);
    chk("xnor_alu_fxn", int'(alu_fxn0), 5);
    drain(0);

    // 256 back-to-back operations, op_count wraps
    for (int i = 0; i < 256; i++) begin
      a = DW'(i * 7);
      b = DW'(i * 13 + 5);
      f = FW'(4 + (i % 4));
      e = alu_ref(a, b, f);
      op(0, a, b, {3'b000, f}, e, 1'b1);
    end
    drain(0);
    @(negedge clk);
    chk("wrap_op_count", int'(op_count0), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
